// File: rtl/tomasulo_pkg.sv
// Shared types and helpers for the LSU/MMU-to-data-memory interface.
package tomasulo_pkg;

  localparam int XLEN       = 32;
  localparam int BYTE_OFF_W = 2;
  localparam int ROB_TAG_W  = 4;

  typedef enum logic [1:0] {
    MEM_B   = 2'b00,
    MEM_H   = 2'b01,
    MEM_W   = 2'b10,
    MEM_RSV = 2'b11
  } mem_size_t;

  typedef struct packed {
    logic [XLEN-1:0]      addr;
    mem_size_t            size;
    logic                 is_unsigned;
    logic [ROB_TAG_W-1:0] tag;
  } dmem_ld_req_t;

  typedef struct packed {
    logic [XLEN-1:0]      data;
    logic [ROB_TAG_W-1:0] tag;
    logic                 err;
  } dmem_ld_resp_t;

  // Out of range, reserved size, or not naturally aligned for its size.
  function automatic logic dmem_req_err(input logic [XLEN-1:0] addr,
                                        input logic [1:0] size,
                                        input int unsigned depth);
    logic [XLEN:0] limit;
    logic          err;
    limit = (XLEN+1)'(depth) << 2;
    err   = ({1'b0, addr} >= limit);
    case (mem_size_t'(size))
      MEM_H:   if (addr[0]) err = 1'b1;
      MEM_W:   if (addr[1:0] != 2'b00) err = 1'b1;
      MEM_RSV: err = 1'b1;
      default: ;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: extracts and extends load data, and shifts store data
// into its lanes together with the matching byte enables.
module dmem_lane_align
  import tomasulo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   word,
  input  logic [BYTE_OFF_W-1:0]   offset,
  input  logic [1:0]              size,
  input  logic                    is_unsigned,
  output logic [DATA_WIDTH-1:0]   ld_data,
  output logic [DATA_WIDTH-1:0]   st_data,
  output logic [DATA_WIDTH/8-1:0] st_be
);
  localparam int NB = DATA_WIDTH / 8;

  logic [BYTE_OFF_W+2:0] sh;
  logic [DATA_WIDTH-1:0] shifted;

  assign sh      = {offset, 3'b000};
  assign shifted = word >> sh;
  assign st_data = word << sh;

  always_comb begin
    ld_data = word;
    st_be   = '1;
    case (mem_size_t'(size))
      MEM_B: begin
        ld_data = {{(DATA_WIDTH-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
        st_be   = NB'(1) << offset;
      end
      MEM_H: begin
        ld_data = {{(DATA_WIDTH-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
        st_be   = NB'(3) << offset;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_pipelined_responder.sv
// Pipelined data memory responder: valid/ready requests, 2-cycle tagged load
// responses, same-cycle store-to-load bypass, array cleared by an init walk.
module dmem_pipelined_responder
  import tomasulo_pkg::*;
#(
  parameter int MEM_DEPTH    = 1024,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_LD_PORTS = 2,
  parameter int NUM_ST_PORTS = 1,
  parameter int TAG_WIDTH    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [NUM_LD_PORTS-1:0]            ld_req_valid,
  output logic [NUM_LD_PORTS-1:0]            ld_req_ready,
  input  logic [NUM_LD_PORTS*32-1:0]         ld_req_addr,
  input  logic [NUM_LD_PORTS*2-1:0]          ld_req_size,
  input  logic [NUM_LD_PORTS-1:0]            ld_req_unsigned,
  input  logic [NUM_LD_PORTS*TAG_WIDTH-1:0]  ld_req_tag,
  output logic [NUM_LD_PORTS-1:0]            ld_resp_valid,
  output logic [NUM_LD_PORTS*DATA_WIDTH-1:0] ld_resp_data,
  output logic [NUM_LD_PORTS*TAG_WIDTH-1:0]  ld_resp_tag,
  output logic [NUM_LD_PORTS-1:0]            ld_resp_err,
  input  logic [NUM_ST_PORTS-1:0]            st_req_valid,
  output logic [NUM_ST_PORTS-1:0]            st_req_ready,
  input  logic [NUM_ST_PORTS*32-1:0]         st_req_addr,
  input  logic [NUM_ST_PORTS*DATA_WIDTH-1:0] st_req_data,
  input  logic [NUM_ST_PORTS*2-1:0]          st_req_size,
  output logic [NUM_ST_PORTS-1:0]            st_ack_valid,
  output logic [NUM_ST_PORTS-1:0]            st_ack_err
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] init_ptr_reg, init_ptr_next;
  logic             run;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_INIT;
      init_ptr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_ptr_reg <= init_ptr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_ptr_next = init_ptr_reg;
    if (state_reg == ST_INIT) begin
      init_ptr_next = init_ptr_reg + IDX_W'(1);
      if (init_ptr_reg == IDX_W'(MEM_DEPTH-1)) begin
        state_next    = ST_RUN;
        init_ptr_next = '0;
      end
    end
  end

  assign run          = (state_reg == ST_RUN);
  assign ld_req_ready = {NUM_LD_PORTS{run}};
  assign st_req_ready = {NUM_ST_PORTS{run}};

  // ---------------- store request decode ----------------
  logic [NUM_ST_PORTS-1:0] st_acc, st_err, st_wen;
  logic [IDX_W-1:0]        st_idx  [NUM_ST_PORTS];
  logic [DATA_WIDTH-1:0]   st_lane [NUM_ST_PORTS];
  logic [NB-1:0]           st_be   [NUM_ST_PORTS];
  logic [DATA_WIDTH-1:0]   st_unused_ld [NUM_ST_PORTS];

  generate
    for (genvar gi = 0; gi < NUM_ST_PORTS; gi++) begin : g_st
      assign st_acc[gi] = st_req_valid[gi] & run;
      assign st_err[gi] = dmem_req_err(st_req_addr[gi*32 +: 32], st_req_size[gi*2 +: 2], MEM_DEPTH);
      assign st_wen[gi] = st_acc[gi] & ~st_err[gi];
      assign st_idx[gi] = st_req_addr[gi*32+2 +: IDX_W];

      dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .word        (st_req_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .offset      (st_req_addr[gi*32 +: BYTE_OFF_W]),
        .size        (st_req_size[gi*2 +: 2]),
        .is_unsigned (1'b1),
        .ld_data     (st_unused_ld[gi]),
        .st_data     (st_lane[gi]),
        .st_be       (st_be[gi])
      );
    end
  endgenerate

  // ---------------- load request decode and bypass ----------------
  logic [NUM_LD_PORTS-1:0] ld_acc, ld_err;
  logic [IDX_W-1:0]        ld_idx   [NUM_LD_PORTS];
  logic [NB-1:0]           byp_be   [NUM_LD_PORTS];
  logic [DATA_WIDTH-1:0]   byp_data [NUM_LD_PORTS];

  generate
    for (genvar gi = 0; gi < NUM_LD_PORTS; gi++) begin : g_ld_dec
      assign ld_acc[gi] = ld_req_valid[gi] & run;
      assign ld_err[gi] = dmem_req_err(ld_req_addr[gi*32 +: 32], ld_req_size[gi*2 +: 2], MEM_DEPTH);
      assign ld_idx[gi] = ld_req_addr[gi*32+2 +: IDX_W];
    end
  endgenerate

  // The array read is read-before-write, so same-cycle store bytes are
  // captured here and merged over the read word in the next stage.
  always_comb begin
    for (int p = 0; p < NUM_LD_PORTS; p++) begin
      byp_be[p]   = '0;
      byp_data[p] = '0;
      for (int s = 0; s < NUM_ST_PORTS; s++) begin
        for (int b = 0; b < NB; b++) begin
          if (st_wen[s] && st_idx[s] == ld_idx[p] && st_be[s][b]) begin
            byp_be[p][b]          = 1'b1;
            byp_data[p][b*8 +: 8] = st_lane[s][b*8 +: 8];
          end
        end
      end
    end
  end

  // ---------------- array: init walk, byte writes, registered reads ----------------
  logic [DATA_WIDTH-1:0] rd_word_reg [NUM_LD_PORTS];

  always_ff @(posedge clk) begin
    if (state_reg == ST_INIT) begin
      mem[init_ptr_reg] <= '0;
    end else begin
      // Ascending port order: the higher store port wins a shared byte.
      for (int s = 0; s < NUM_ST_PORTS; s++) begin
        for (int b = 0; b < NB; b++) begin
          if (st_wen[s] && st_be[s][b]) mem[st_idx[s]][b*8 +: 8] <= st_lane[s][b*8 +: 8];
        end
      end
    end
    for (int p = 0; p < NUM_LD_PORTS; p++) rd_word_reg[p] <= mem[ld_idx[p]];
  end

  // ---------------- S1 / S2 pipeline ----------------
  logic [NUM_LD_PORTS-1:0] s1_valid_reg, s1_err_reg, s1_uns_reg, s2_live;
  logic [BYTE_OFF_W-1:0]   s1_off_reg      [NUM_LD_PORTS];
  logic [1:0]              s1_size_reg     [NUM_LD_PORTS];
  logic [TAG_WIDTH-1:0]    s1_tag_reg      [NUM_LD_PORTS];
  logic [NB-1:0]           s1_byp_be_reg   [NUM_LD_PORTS];
  logic [DATA_WIDTH-1:0]   s1_byp_data_reg [NUM_LD_PORTS];
  logic [DATA_WIDTH-1:0]   merged          [NUM_LD_PORTS];
  logic [DATA_WIDTH-1:0]   ld_ext          [NUM_LD_PORTS];
  logic [DATA_WIDTH-1:0]   ld_unused_st    [NUM_LD_PORTS];
  logic [NB-1:0]           ld_unused_be    [NUM_LD_PORTS];

  assign s2_live = s1_valid_reg & ~{NUM_LD_PORTS{flush}};

  generate
    for (genvar gi = 0; gi < NUM_LD_PORTS; gi++) begin : g_ld_s2
      for (genvar gb = 0; gb < NB; gb++) begin : g_byte
        assign merged[gi][gb*8 +: 8] = s1_byp_be_reg[gi][gb] ? s1_byp_data_reg[gi][gb*8 +: 8]
                                                              : rd_word_reg[gi][gb*8 +: 8];
      end

      dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .word        (merged[gi]),
        .offset      (s1_off_reg[gi]),
        .size        (s1_size_reg[gi]),
        .is_unsigned (s1_uns_reg[gi]),
        .ld_data     (ld_ext[gi]),
        .st_data     (ld_unused_st[gi]),
        .st_be       (ld_unused_be[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg  <= '0;
      s1_err_reg    <= '0;
      s1_uns_reg    <= '0;
      ld_resp_valid <= '0;
      ld_resp_data  <= '0;
      ld_resp_tag   <= '0;
      ld_resp_err   <= '0;
      st_ack_valid  <= '0;
      st_ack_err    <= '0;
      for (int p = 0; p < NUM_LD_PORTS; p++) begin
        s1_off_reg[p]      <= '0;
        s1_size_reg[p]     <= '0;
        s1_tag_reg[p]      <= '0;
        s1_byp_be_reg[p]   <= '0;
        s1_byp_data_reg[p] <= '0;
      end
    end else begin
      s1_valid_reg  <= ld_acc & ~{NUM_LD_PORTS{flush}};
      ld_resp_valid <= s2_live;
      st_ack_valid  <= st_acc;
      st_ack_err    <= st_acc & st_err;
      for (int p = 0; p < NUM_LD_PORTS; p++) begin
        if (ld_acc[p]) begin
          s1_err_reg[p]      <= ld_err[p];
          s1_uns_reg[p]      <= ld_req_unsigned[p];
          s1_off_reg[p]      <= ld_req_addr[p*32 +: BYTE_OFF_W];
          s1_size_reg[p]     <= ld_req_size[p*2 +: 2];
          s1_tag_reg[p]      <= ld_req_tag[p*TAG_WIDTH +: TAG_WIDTH];
          s1_byp_be_reg[p]   <= byp_be[p];
          s1_byp_data_reg[p] <= byp_data[p];
        end
        ld_resp_data[p*DATA_WIDTH +: DATA_WIDTH] <= (s2_live[p] && !s1_err_reg[p]) ? ld_ext[p] : '0;
        ld_resp_tag[p*TAG_WIDTH +: TAG_WIDTH]    <= s2_live[p] ? s1_tag_reg[p] : '0;
        ld_resp_err[p]                           <= s2_live[p] & s1_err_reg[p];
      end
    end
  end

endmodule

// File: tb/tb_dmem_pipelined_responder.sv
// Directed bench for dmem_pipelined_responder: init length, load extension,
// bypass, error checks, flush and reset behaviour.
module tb_dmem_pipelined_responder;
  localparam int NL = 2;
  localparam int NS = 1;
  localparam int TW = 4;
  localparam int DW = 32;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_R = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [NL-1:0]    ld_req_valid, ld_req_ready, ld_req_unsigned, ld_resp_valid, ld_resp_err;
  logic [NL*32-1:0] ld_req_addr;
  logic [NL*2-1:0]  ld_req_size;
  logic [NL*TW-1:0] ld_req_tag, ld_resp_tag;
  logic [NL*DW-1:0] ld_resp_data;
  logic [NS-1:0]    st_req_valid, st_req_ready, st_ack_valid, st_ack_err;
  logic [NS*32-1:0] st_req_addr;
  logic [NS*DW-1:0] st_req_data;
  logic [NS*2-1:0]  st_req_size;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dmem_pipelined_responder dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
    .ld_req_size(ld_req_size), .ld_req_unsigned(ld_req_unsigned), .ld_req_tag(ld_req_tag),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data), .ld_resp_tag(ld_resp_tag),
    .ld_resp_err(ld_resp_err),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_req_addr(st_req_addr),
    .st_req_data(st_req_data), .st_req_size(st_req_size),
    .st_ack_valid(st_ack_valid), .st_ack_err(st_ack_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    ld_req_valid = '0; ld_req_addr = '0; ld_req_size = '0; ld_req_unsigned = '0; ld_req_tag = '0;
    st_req_valid = '0; st_req_addr = '0; st_req_data = '0; st_req_size = '0;
  endtask

  task automatic drive_ld(input int p, input logic [31:0] a, input logic [1:0] sz,
                          input logic uns, input logic [TW-1:0] tag);
    ld_req_valid[p]         = 1'b1;
    ld_req_addr[p*32 +: 32] = a;
    ld_req_size[p*2 +: 2]   = sz;
    ld_req_unsigned[p]      = uns;
    ld_req_tag[p*TW +: TW]  = tag;
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [DW-1:0] d, input logic [1:0] sz);
    st_req_valid = 1'b1;
    st_req_addr  = a;
    st_req_data  = d;
    st_req_size  = sz;
  endtask

  // {valid, err, tag, data} of one response port
  function automatic logic [37:0] resp_of(input int p);
    return {ld_resp_valid[p], ld_resp_err[p], ld_resp_tag[p*TW +: TW], ld_resp_data[p*DW +: DW]};
  endfunction

  task automatic show(input string what);
    $display("%-10s t=%0t p0 v%b e%b tag %h data %h | p1 v%b e%b tag %h data %h | ack v%b e%b",
             what, $time, ld_resp_valid[0], ld_resp_err[0], ld_resp_tag[3:0], ld_resp_data[31:0],
             ld_resp_valid[1], ld_resp_err[1], ld_resp_tag[7:4], ld_resp_data[63:32],
             st_ack_valid, st_ack_err);
  endtask

  task automatic test_reset();
    int cnt;
    clear_reqs();
    #1 rst = 1'b0;
    #1;
    nvec++;
    if ({ld_req_ready, st_req_ready, ld_resp_valid, ld_resp_err, st_ack_valid, st_ack_err} !== 10'b0) begin
      nerr++;
      $display("FAIL reset_ctrl: got %b want 0",
               {ld_req_ready, st_req_ready, ld_resp_valid, ld_resp_err, st_ack_valid, st_ack_err});
    end
    nvec++;
    if ({ld_resp_data, ld_resp_tag} !== 72'b0) begin
      nerr++;
      $display("FAIL reset_data: got %h want 0", {ld_resp_data, ld_resp_tag});
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cnt = 0;
    while (ld_req_ready == '0 && cnt < 2000) begin
      step();
      cnt++;
    end
    $display("init      ready after %0d cycles", cnt);
    nvec++;
    if (cnt !== 1024) begin
      nerr++;
      $display("FAIL init_len: got %0d want 1024", cnt);
    end
    nvec++;
    if ({ld_req_ready, st_req_ready} !== 3'b111) begin
      nerr++;
      $display("FAIL ready_run: got %b want 111", {ld_req_ready, st_req_ready});
    end
  endtask

  task automatic test_zero_load();
    logic [37:0] exp;
    drive_ld(0, 32'h10, SZ_W, 1'b0, 4'h9);
    drive_ld(1, 32'hFFC, SZ_W, 1'b0, 4'h2);
    step();
    clear_reqs();
    nvec++;
    if (ld_resp_valid !== 2'b00) begin
      nerr++;
      $display("FAIL zero_early: got %b want 00", ld_resp_valid);
    end
    step();
    show("zero");
    exp = {1'b1, 1'b0, 4'h9, 32'h0};
    nvec++;
    if (resp_of(0) !== exp) begin
      nerr++;
      $display("FAIL zero_p0: got %h want %h", resp_of(0), exp);
    end
    exp = {1'b1, 1'b0, 4'h2, 32'h0};
    nvec++;
    if (resp_of(1) !== exp) begin
      nerr++;
      $display("FAIL last_word_p1: got %h want %h", resp_of(1), exp);
    end
    step();
    nvec++;
    if (ld_resp_valid !== 2'b00) begin
      nerr++;
      $display("FAIL zero_pulse: got %b want 00", ld_resp_valid);
    end
  endtask

  task automatic test_store_load();
    logic [37:0] exp;
    drive_st(32'h20, 32'h8000_00F5, SZ_W);
    step();
    clear_reqs();
    nvec++;
    if ({st_ack_valid, st_ack_err} !== 2'b10) begin
      nerr++;
      $display("FAIL st_ack: got %b want 10", {st_ack_valid, st_ack_err});
    end
    drive_ld(0, 32'h20, SZ_B, 1'b0, 4'h3);
    drive_ld(1, 32'h22, SZ_H, 1'b1, 4'h5);
    step();
    clear_reqs();
    nvec++;
    if (st_ack_valid !== 1'b0) begin
      nerr++;
      $display("FAIL st_ack_pulse: got %b want 0", st_ack_valid);
    end
    step();
    show("st_ld");
    exp = {1'b1, 1'b0, 4'h3, 32'hFFFF_FFF5};
    nvec++;
    if (resp_of(0) !== exp) begin
      nerr++;
      $display("FAIL lb_signed: got %h want %h", resp_of(0), exp);
    end
    exp = {1'b1, 1'b0, 4'h5, 32'h0000_8000};
    nvec++;
    if (resp_of(1) !== exp) begin
      nerr++;
      $display("FAIL lhu: got %h want %h", resp_of(1), exp);
    end
  endtask

  task automatic test_bypass();
    logic [37:0] exp;
    drive_st(32'h40, 32'h1122_3344, SZ_W);
    step();
    clear_reqs();
    step();
    drive_st(32'h41, 32'h0000_00AB, SZ_B);
    drive_ld(0, 32'h40, SZ_W, 1'b0, 4'h6);
    drive_ld(1, 32'h42, SZ_H, 1'b1, 4'h2);
    step();
    clear_reqs();
    drive_ld(0, 32'h40, SZ_H, 1'b0, 4'h1);
    drive_ld(1, 32'h43, SZ_B, 1'b1, 4'hF);
    step();
    clear_reqs();
    show("bypass");
    exp = {1'b1, 1'b0, 4'h6, 32'h1122_AB44};
    nvec++;
    if (resp_of(0) !== exp) begin
      nerr++;
      $display("FAIL bypass_word: got %h want %h", resp_of(0), exp);
    end
    exp = {1'b1, 1'b0, 4'h2, 32'h0000_1122};
    nvec++;
    if (resp_of(1) !== exp) begin
      nerr++;
      $display("FAIL bypass_upper: got %h want %h", resp_of(1), exp);
    end
    step();
    show("post_st");
    exp = {1'b1, 1'b0, 4'h1, 32'hFFFF_AB44};
    nvec++;
    if (resp_of(0) !== exp) begin
      nerr++;
      $display("FAIL lh_signed: got %h want %h", resp_of(0), exp);
    end
    exp = {1'b1, 1'b0, 4'hF, 32'h0000_0011};
    nvec++;
    if (resp_of(1) !== exp) begin
      nerr++;
      $display("FAIL lbu_top: got %h want %h", resp_of(1), exp);
    end
  endtask

  task automatic test_errors();
    logic [37:0] exp;
    drive_ld(0, 32'h42, SZ_W, 1'b0, 4'h7);
    drive_ld(1, 32'h1000, SZ_W, 1'b0, 4'h8);
    drive_st(32'h43, 32'h0000_BEEF, SZ_H);
    step();
    clear_reqs();
    nvec++;
    if ({st_ack_valid, st_ack_err} !== 2'b11) begin
      nerr++;
      $display("FAIL st_misalign: got %b want 11", {st_ack_valid, st_ack_err});
    end
    step();
    show("err");
    exp = {1'b1, 1'b1, 4'h7, 32'h0};
    nvec++;
    if (resp_of(0) !== exp) begin
      nerr++;
      $display("FAIL ld_misalign: got %h want %h", resp_of(0), exp);
    end
    exp = {1'b1, 1'b1, 4'h8, 32'h0};
    nvec++;
    if (resp_of(1) !== exp) begin
      nerr++;
      $display("FAIL ld_range: got %h want %h", resp_of(1), exp);
    end
    drive_st(32'h1000, 32'hDEAD_BEEF, SZ_W);
    drive_ld(1, 32'h0, SZ_R, 1'b0, 4'h4);
    step();
    clear_reqs();
    nvec++;
    if ({st_ack_valid, st_ack_err} !== 2'b11) begin
      nerr++;
      $display("FAIL st_range: got %b want 11", {st_ack_valid, st_ack_err});
    end
    drive_ld(0, 32'h40, SZ_W, 1'b0, 4'h9);
    drive_ld(1, 32'h0, SZ_W, 1'b0, 4'hA);
    step();
    clear_reqs();
    exp = {1'b1, 1'b1, 4'h4, 32'h0};
    nvec++;
    if (resp_of(1) !== exp) begin
      nerr++;
      $display("FAIL ld_rsv: got %h want %h", resp_of(1), exp);
    end
    step();
    show("unchanged");
    exp = {1'b1, 1'b0, 4'h9, 32'h1122_AB44};
    nvec++;
    if (resp_of(0) !== exp) begin
      nerr++;
      $display("FAIL keep_40: got %h want %h", resp_of(0), exp);
    end
    exp = {1'b1, 1'b0, 4'hA, 32'h0};
    nvec++;
    if (resp_of(1) !== exp) begin
      nerr++;
      $display("FAIL keep_0: got %h want %h", resp_of(1), exp);
    end
  endtask

  task automatic test_flush();
    logic [37:0] exp;
    drive_ld(0, 32'h20, SZ_W, 1'b0, 4'h1);
    step();
    clear_reqs();
    flush = 1'b1;
    drive_st(32'h24, 32'hCAFE_F00D, SZ_W);
    step();
    flush = 1'b0;
    clear_reqs();
    nvec++;
    if (ld_resp_valid !== 2'b00) begin
      nerr++;
      $display("FAIL flush_kill: got %b want 00", ld_resp_valid);
    end
    nvec++;
    if ({st_ack_valid, st_ack_err} !== 2'b10) begin
      nerr++;
      $display("FAIL flush_store: got %b want 10", {st_ack_valid, st_ack_err});
    end
    drive_ld(0, 32'h20, SZ_W, 1'b0, 4'h2);
    drive_ld(1, 32'h24, SZ_W, 1'b0, 4'hC);
    step();
    clear_reqs();
    nvec++;
    if (ld_resp_valid !== 2'b00) begin
      nerr++;
      $display("FAIL flush_gap: got %b want 00", ld_resp_valid);
    end
    step();
    show("flush");
    exp = {1'b1, 1'b0, 4'h2, 32'h8000_00F5};
    nvec++;
    if (resp_of(0) !== exp) begin
      nerr++;
      $display("FAIL after_flush: got %h want %h", resp_of(0), exp);
    end
    exp = {1'b1, 1'b0, 4'hC, 32'hCAFE_F00D};
    nvec++;
    if (resp_of(1) !== exp) begin
      nerr++;
      $display("FAIL flush_st_data: got %h want %h", resp_of(1), exp);
    end
    drive_ld(0, 32'h20, SZ_W, 1'b0, 4'h3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    clear_reqs();
    step();
    nvec++;
    if (ld_resp_valid !== 2'b00) begin
      nerr++;
      $display("FAIL flush_same: got %b want 00", ld_resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr_t [3] = '{32'h20, 32'h24, 32'h22};
    logic [1:0]  size_t [3] = '{SZ_W, SZ_W, SZ_H};
    logic [31:0] data_t [3] = '{32'h8000_00F5, 32'hCAFE_F00D, 32'h0000_8000};
    logic [37:0] exp;
    for (int i = 0; i < 4; i++) begin
      clear_reqs();
      if (i < 3) drive_ld(0, addr_t[i], size_t[i], 1'b1, TW'(i + 1));
      step();
      if (i >= 1) begin
        show("b2b");
        exp = {1'b1, 1'b0, TW'(i), data_t[i-1]};
        nvec++;
        if (resp_of(0) !== exp) begin
          nerr++;
          $display("FAIL b2b_%0d: got %h want %h", i - 1, resp_of(0), exp);
        end
      end
    end
    clear_reqs();
  endtask

  task automatic test_reset_again();
    logic [37:0] exp;
    int cnt;
    drive_ld(0, 32'h20, SZ_W, 1'b0, 4'h6);
    step();
    clear_reqs();
    step();
    nvec++;
    if (ld_resp_valid[0] !== 1'b1) begin
      nerr++;
      $display("FAIL pre_reset_valid: got %b want 1", ld_resp_valid[0]);
    end
    #2 rst = 1'b0;
    #1;
    nvec++;
    if ({ld_resp_valid, ld_resp_err, ld_resp_tag, ld_resp_data, ld_req_ready, st_req_ready} !== 77'b0) begin
      nerr++;
      $display("FAIL async_clear: got %h want 0",
               {ld_resp_valid, ld_resp_err, ld_resp_tag, ld_resp_data, ld_req_ready, st_req_ready});
    end
    step();
    rst = 1'b1;
    repeat (500) step();
    rst = 1'b0;
    #1;
    nvec++;
    if ({ld_req_ready, st_req_ready} !== 3'b000) begin
      nerr++;
      $display("FAIL init500_ready: got %b want 000", {ld_req_ready, st_req_ready});
    end
    step();
    rst = 1'b1;
    cnt = 0;
    while (ld_req_ready == '0 && cnt < 2000) begin
      step();
      cnt++;
    end
    $display("reinit    ready after %0d cycles", cnt);
    nvec++;
    if (cnt !== 1024) begin
      nerr++;
      $display("FAIL reinit_len: got %0d want 1024", cnt);
    end
    drive_ld(0, 32'h20, SZ_W, 1'b0, 4'h3);
    step();
    clear_reqs();
    step();
    show("cleared");
    exp = {1'b1, 1'b0, 4'h3, 32'h0};
    nvec++;
    if (resp_of(0) !== exp) begin
      nerr++;
      $display("FAIL cleared_20: got %h want %h", resp_of(0), exp);
    end
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_zero_load();
    test_store_load();
    test_bypass();
    test_errors();
    test_flush();
    test_back_to_back();
    test_reset_again();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
